operand_sequencer: RTL and testbench
====================================

Name: operand_sequencer

Overview:
Upstream input stage for the logic unit of the Mini-CPU. It takes the board switches and one pushbutton and captures operand x, then operand y, then the 2-bit operation select, in sequence. It presents these as stable registered operands with a valid/ready handshake to the logic/ALU stage. The pushbutton is synchronised and debounced inside the block, and a small FSM steps through the capture sequence.

Parameters:
DATA_W, 4, operand width (x, y)
OP_W, 2, operation select width (SW9:SW8; 00 AND, 01 OR, 10 XOR, 11 NOT)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
sw_data  in  DATA_W  raw data switches SW[3:0], quasi-static
sw_op  in  OP_W  raw op switches {SW9,SW8}
key_n  in  1  raw pushbutton, active-low, asynchronous, bouncy
x  out  DATA_W  captured operand x
y  out  DATA_W  captured operand y
op  out  OP_W  captured operation select
out_valid  out  1  x/y/op complete and stable
out_ready  in  1  downstream accepts operands
state  out  2  current FSM state, for LED display

Behaviour:
- Reset (rst_n low at a clk edge):
  - x=0, y=0, op=0, out_valid=0, state=S_X.
  - Synchroniser flops=1; debounced level=1 (released); debounce counter=0; press pulse=0.
- Synchroniser: 2 flip-flops on key_n.
- Debouncer:
  - Counter increments every cycle that the synchroniser output differs from the debounced level.
  - Counter clears to 0 whenever they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the synchroniser value and the counter clears.
  - Counter width = $clog2(DEBOUNCE_CYCLES+1).
- Press pulse: registered, 1 cycle wide, asserted on a debounced 1->0 transition only. Release produces no pulse.
- Latency: with key_n held low from the sampling edge E, the FSM acts on edge E+DEBOUNCE_CYCLES+4.
- Glitch rejection: low pulses shorter than DEBOUNCE_CYCLES cycles after synchronisation produce no press.
- FSM states, encoding S_X=0, S_Y=1, S_OP=2, S_VALID=3:
  - S_X: on press, x<=sw_data; go to S_Y.
  - S_Y: on press, y<=sw_data; go to S_OP.
  - S_OP: on press, op<=sw_op; go to S_VALID.
  - S_VALID: out_valid=1; x/y/op held.
    - out_valid&&out_ready: transfer completes. x, y, op keep their values; out_valid=0 next cycle; go to S_X.
    - Press without ready: abort; out_valid=0; go to S_X; x, y, op keep their values.
    - Press and ready in the same cycle: transfer wins and the press is dropped. Next state S_X, with no capture of x that cycle.
- out_valid is registered, and is 1 exactly when state==S_VALID.
- out_ready is ignored in every state except S_VALID.
- A new x is captured only by a press in S_X.
- Reset mid-sequence returns to S_X with cleared outputs; any press in progress is lost.
- sw_data and sw_op are sampled only on a press cycle. No synchroniser is needed for them because the switches are quasi-static.

Optional Feature:
OPSEQ_OP_LIVE_EN
- Defined:
  - S_OP is skipped: a press in S_Y captures y and goes straight to S_VALID.
  - op is driven combinationally from sw_op in every state, so the operation can be changed while the result is displayed.
  - State encoding is unchanged; 2 is never entered.
- Undefined: behaviour as above, with op latched in S_OP.

Decomposition:
- Package opseq_pkg: state enum (S_X, S_Y, S_OP, S_VALID), op encodings (OP_AND=0, OP_OR=1, OP_XOR=2, OP_NOT=3), DATA_W/OP_W defaults. The op encodings are shared with the logic stage.
- One sub-module: key_debounce. It contains the synchroniser, debounce counter and press-pulse register; parameter DEBOUNCE_CYCLES; ports clk, rst_n, key_n, press.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Basic sequence:
  - Stimulus: sw_data=4'hA press, 4'h5 press, sw_op=2'b10 press; out_ready=1 after 3 cycles of valid.
  - Response: x=A, y=5, op=2, out_valid=1 for 3 cycles; then out_valid=0 and state=0.
- Latency: key_n low at edge E with other inputs static -> x updates at edge E+8, not earlier.
- Bounce: key_n low for 3 cycles then high, repeated 5 times -> no state change; state stays 0.
- Abort and simultaneous:
  - Press in S_VALID with out_ready=0 -> state=0, out_valid=0, x/y/op unchanged.
  - Repeat with press coincident with out_ready=1 -> single transfer, state=0, x not recaptured.
- Reset mid-sequence: rst_n low for 1 cycle while in S_OP -> x=y=op=0, state=0, out_valid=0; the following press captures x.
- OPSEQ_OP_LIVE_EN build: after x and y presses, state=3; toggling sw_op 0->3 -> op follows in the same cycle with no press needed.

Source files
------------

// File: rtl/opseq_pkg.sv
// Shared types and constants for the operand sequencer and the downstream logic stage.
package opseq_pkg;

    localparam int OPSEQ_DATA_W = 4;
    localparam int OPSEQ_OP_W   = 2;

    typedef enum logic [1:0] {
        S_X     = 2'd0,
        S_Y     = 2'd1,
        S_OP    = 2'd2,
        S_VALID = 2'd3
    } state_t;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_NOT = 2'd3;

endpackage

// File: rtl/operand_sequencer_key_debounce.sv
// Pushbutton conditioning: 2-flop synchroniser, stable-level debouncer and a
// registered one-cycle press pulse on each debounced press (1->0).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= key_n;
            sync2   <= sync1;
            level_d <= level;
            // Pulse is taken from the settled level so a release never fires it.
            press   <= level_d & ~level;
            if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                level <= sync2;
                cnt   <= '0;
            end else if (sync2 != level) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/operand_sequencer.sv
// Captures x, y and op from the switches on successive button presses and offers
// them downstream with a valid/ready handshake. Optional macro: OPSEQ_OP_LIVE_EN.
module operand_sequencer
    import opseq_pkg::*;
#(
    parameter int DATA_W          = OPSEQ_DATA_W,
    parameter int OP_W            = OPSEQ_OP_W,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [OP_W-1:0]   sw_op,
    input  logic              key_n,
    output logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y,
    output logic [OP_W-1:0]   op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        state
);

    // Handshake: a transfer happens on any rising edge where out_valid && out_ready;
    // out_valid stays high with x/y/op held until that edge or an abort press.
    logic              press;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] x_q, x_d, y_q, y_d;
    logic              valid_q, valid_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(key_n),
        .press(press)
    );

`ifdef OPSEQ_OP_LIVE_EN
    assign op = sw_op;
`else
    logic [OP_W-1:0] op_q, op_d;
    assign op = op_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_X;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
`ifndef OPSEQ_OP_LIVE_EN
            op_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
`ifndef OPSEQ_OP_LIVE_EN
            op_q    <= op_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
`ifndef OPSEQ_OP_LIVE_EN
        op_d    = op_q;
`endif
        case (state_q)
            S_X: begin
                if (press) begin
                    x_d     = sw_data;
                    state_d = S_Y;
                end
            end
            S_Y: begin
                if (press) begin
                    y_d     = sw_data;
`ifdef OPSEQ_OP_LIVE_EN
                    state_d = S_VALID;
`else
                    state_d = S_OP;
`endif
                end
            end
            S_OP: begin
`ifdef OPSEQ_OP_LIVE_EN
                state_d = S_X;
`else
                if (press) begin
                    op_d    = sw_op;
                    state_d = S_VALID;
                end
`endif
            end
            S_VALID: begin
                // Ready means transfer, a press means abort; both just return to S_X.
                if (out_ready || press) begin
                    state_d = S_X;
                end
            end
            default: state_d = S_X;
        endcase
        valid_d = (state_d == S_VALID);
    end

    assign x         = x_q;
    assign y         = y_q;
    assign out_valid = valid_q;
    assign state     = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Randomised scoreboard bench for operand_sequencer with a short debounce window.
module tb_operand_sequencer;

    localparam int DW = 4;
    localparam int OW = 2;
    localparam int DB = 4;
`ifdef OPSEQ_OP_LIVE_EN
    localparam bit LIVE = 1'b1;
`else
    localparam bit LIVE = 1'b0;
`endif
    localparam int LAST_CAP = LIVE ? 1 : 2;
    localparam int HOLD = DB + 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] sw_data;
    logic [OW-1:0] sw_op;
    logic          key_n;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [OW-1:0] op;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    state;

    operand_sequencer #(
        .DATA_W(DW),
        .OP_W(OW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_data  (sw_data),
        .sw_op    (sw_op),
        .key_n    (key_n),
        .x        (x),
        .y        (y),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .state    (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [2*DW+OW-1:0] exp_q[$];
    int exp_xfer = 0;
    int xfer_seen = 0;
    bit prev_valid = 1'b0;

    // Reference model: which field the next press fills, and the captured values.
    int          m_stage = 0;
    logic [DW-1:0] m_x = '0;
    logic [DW-1:0] m_y = '0;
    logic [OW-1:0] m_op = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        logic [OW-1:0] e_op;
        e_op = LIVE ? sw_op : m_op;
        check({tag, "_state"}, 32'(state), 32'(m_stage));
        check({tag, "_x"}, 32'(x), 32'(m_x));
        check({tag, "_y"}, 32'(y), 32'(m_y));
        check({tag, "_op"}, 32'(op), 32'(e_op));
        check({tag, "_valid"}, 32'(out_valid), 32'(m_stage == 3));
    endtask

    task automatic press(input logic [DW-1:0] d, input logic [OW-1:0] o);
        bit rnd_ready;
        rnd_ready = (m_stage < LAST_CAP);
        case (m_stage)
            0: begin m_x = d; m_stage = 1; end
            1: begin m_y = d; m_stage = LIVE ? 3 : 2; end
            2: begin m_op = o; m_stage = 3; end
            default: m_stage = 0;
        endcase
        if (rnd_ready == 1'b0 && m_stage == 3)
            exp_q.push_back({m_x, m_y, (LIVE ? o : m_op)});
        sw_data = d;
        sw_op = o;
        key_n = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        out_ready = 1'b0;
        key_n = 1'b1;
        repeat (HOLD) tick();
    endtask

    task automatic deliver(input int wait_cycles);
        for (int i = 0; i < wait_cycles; i++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        m_stage = 0;
        exp_xfer++;
        check_outputs("after_xfer");
    endtask

    task automatic fill_random();
        for (int k = 0; k <= LAST_CAP; k++) begin
            press(DW'($urandom), OW'($urandom));
            check_outputs("fill");
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got x=%0h y=%0h op=%0h expected no valid", x, y, op);
            end else begin
                check("valid_payload", 32'({x, y, op}), 32'(exp_q.pop_front()));
            end
        end
        if (rst_n && out_valid && out_ready) xfer_seen++;
        prev_valid = out_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] old_x;
        rst_n = 1'b0;
        key_n = 1'b1;
        out_ready = 1'b0;
        sw_data = '0;
        sw_op = '0;
        repeat (3) tick();
        check_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic sequence: A, 5, XOR; valid held three cycles before ready.
        press(4'hA, 2'b00);
        check_outputs("basic_x");
        press(4'h5, 2'b00);
        check_outputs("basic_y");
        if (!LIVE) begin
            press(4'h0, 2'b10);
            check_outputs("basic_op");
        end
        deliver(3);

        // Latency: key low sampled at edge E, x changes on edge E+8 and not before.
        old_x = m_x;
        sw_data = 4'hC;
        key_n = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 8) check("latency_early", 32'(x), 32'(old_x));
            if (i == 9) check("latency_on_time", 32'(x), 32'hC);
        end
        m_x = 4'hC;
        m_stage = 1;
        repeat (HOLD) tick();
        key_n = 1'b1;
        repeat (HOLD) tick();
        check_outputs("latency_after");

        // Bounce: five 3-cycle low pulses must not register as a press.
        for (int n = 0; n < 5; n++) begin
            key_n = 1'b0;
            repeat (3) tick();
            key_n = 1'b1;
            repeat (3) tick();
        end
        repeat (HOLD) tick();
        check_outputs("bounce");

        // Finish this sequence, then abort it with a press while not ready.
        for (int k = 1; k <= LAST_CAP; k++) begin
            press(DW'($urandom), OW'($urandom));
            check_outputs("pre_abort");
        end
        press(DW'($urandom), OW'($urandom));
        check_outputs("abort");

        // Press and ready arriving together: transfer wins, no x capture.
        fill_random();
        sw_data = ~m_x;
        key_n = 1'b0;
        repeat (8) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        m_stage = 0;
        exp_xfer++;
        check_outputs("simul");
        repeat (HOLD) tick();
        key_n = 1'b1;
        repeat (HOLD) tick();
        check_outputs("simul_idle");

        // Reset mid-sequence clears everything; the next press captures x.
        press(DW'($urandom), OW'($urandom));
        if (!LIVE) press(DW'($urandom), OW'($urandom));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_stage = 0;
        m_x = '0;
        m_y = '0;
        m_op = '0;
        check_outputs("mid_reset");
        press(4'h9, 2'b01);
        check_outputs("post_reset_x");
        m_stage = 1;
        for (int k = 1; k <= LAST_CAP; k++) begin
            press(DW'($urandom), OW'($urandom));
            check_outputs("post_reset_fill");
        end
        deliver(1);

`ifdef OPSEQ_OP_LIVE_EN
        fill_random();
        sw_op = 2'b00;
        #1;
        check("live_op0", 32'(op), 32'd0);
        sw_op = 2'b11;
        #1;
        check("live_op3", 32'(op), 32'd3);
        check("live_state", 32'(state), 32'd3);
        deliver(0);
`endif

        // Randomised transactions with occasional aborts.
        for (int t = 0; t < 8; t++) begin
            fill_random();
            if ($urandom_range(0, 3) == 0) begin
                press(DW'($urandom), OW'($urandom));
                check_outputs("rand_abort");
            end else begin
                deliver($urandom_range(0, 4));
            end
        end

        repeat (4) tick();
        check("xfer_count", 32'(xfer_seen), 32'(exp_xfer));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
